// File: rtl/sys_bus_hs_pkg.sv
// Shared definitions for the single-master system bus: FSM state encoding,
// default slave region heads, bus widths and the registered request bundle.
package sys_bus_hs_pkg;

  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_BEW = BUS_DW / 8;

  // Default region heads (addr[31:28]) of the core peripherals.
  localparam logic [3:0] HEAD_DMEM = 4'h1;
  localparam logic [3:0] HEAD_GPIO = 4'h2;
  localparam logic [3:0] HEAD_UART = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  // Master request as captured in IDLE and presented to every slave.
  typedef struct packed {
    logic [BUS_AW-1:0]  addr;
    logic [BUS_DW-1:0]  wdata;
    logic               wen;
    logic [BUS_BEW-1:0] be;
  } bus_req_t;

endpackage

// File: rtl/sys_bus_decode.sv
// Combinational region decoder: maps addr[31:28] onto a one-hot slave select
// plus a hit flag. When several slaves share a head, the lowest index wins.
module sys_bus_decode
  import sys_bus_hs_pkg::*;
#(
  parameter int unsigned          NUM_SLV  = 3,
  parameter logic [NUM_SLV*4-1:0] SLV_HEAD = {HEAD_UART, HEAD_GPIO, HEAD_DMEM}
) (
  input  logic [3:0]         addr_head,
  output logic [NUM_SLV-1:0] sel,
  output logic               hit
);

  // Scan from the highest index down so the lowest matching index is the last write.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    sel = '0;
    hit = 1'b0;
    for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
      if (addr_head == SLV_HEAD[4*i +: 4]) begin
        sel    = '0;
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sys_bus_hs.sv
// Single-master system bus with valid/ready handshake and slave wait states.
// One transaction in flight: IDLE captures the request, ACCESS holds the
// one-hot s_req until the selected slave answers, RESP pulses m_ready.
// Unmapped addresses answer with m_err. Optional slave timeout is enabled by
// defining the macro BUS_TIMEOUT_EN.
module sys_bus_hs
  import sys_bus_hs_pkg::*;
#(
  parameter int unsigned          NUM_SLV     = 3,
  parameter logic [NUM_SLV*4-1:0] SLV_HEAD    = {HEAD_UART, HEAD_GPIO, HEAD_DMEM},
  parameter int unsigned          TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m_req,
  input  logic [BUS_AW-1:0]       m_addr,
  input  logic [BUS_DW-1:0]       m_wdata,
  input  logic                    m_wen,
  input  logic [BUS_BEW-1:0]      m_be,
  output logic [BUS_DW-1:0]       m_rdata,
  output logic                    m_ready,
  output logic                    m_err,
  output logic [BUS_AW-1:0]       err_addr,
  output logic [NUM_SLV-1:0]      s_req,
  output logic [BUS_AW-1:0]       s_addr,
  output logic [BUS_DW-1:0]       s_wdata,
  output logic                    s_wen,
  output logic [BUS_BEW-1:0]      s_be,
  input  logic [NUM_SLV*BUS_DW-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]      s_ready
);

  if (NUM_SLV < 1 || NUM_SLV > 15) begin : g_bad_num_slv
    $error("sys_bus_hs: NUM_SLV must be 1..15");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("sys_bus_hs: TIMEOUT_CYC must fit the 8-bit timeout counter (1..255)");
  end

  bus_state_e          state_q, state_d;
  logic [NUM_SLV-1:0]  sel_q, sel_d;
  logic [NUM_SLV-1:0]  s_req_q, s_req_d;
  bus_req_t            req_q, req_d;
  logic                m_ready_q, m_ready_d;
  logic                m_err_q, m_err_d;
  logic [BUS_DW-1:0]   m_rdata_q, m_rdata_d;
  logic [BUS_AW-1:0]   err_addr_q, err_addr_d;
`ifdef BUS_TIMEOUT_EN
  logic [7:0]          cnt_q, cnt_d;
`endif

  logic [NUM_SLV-1:0]  dec_sel;
  logic                dec_hit;
  logic                sel_ready;
  logic [BUS_DW-1:0]   sel_rdata;

  sys_bus_decode #(
    .NUM_SLV  (NUM_SLV),
    .SLV_HEAD (SLV_HEAD)
  ) u_decode (
    .addr_head (m_addr[31:28]),
    .sel       (dec_sel),
    .hit       (dec_hit)
  );

  // Only the selected slave's ready and read data are ever looked at.
  always_comb begin
    sel_ready = |(s_ready & sel_q);
    sel_rdata = '0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if (sel_q[i]) sel_rdata |= s_rdata[BUS_DW*i +: BUS_DW];
    end
  end

  // Next-state and next-output logic; m_ready/m_err are one-cycle pulses into RESP.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    s_req_d    = s_req_q;
    req_d      = req_q;
    m_ready_d  = 1'b0;
    m_err_d    = 1'b0;
    m_rdata_d  = m_rdata_q;
    err_addr_d = err_addr_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          req_d = '{addr: m_addr, wdata: m_wdata, wen: m_wen, be: m_be};
          if (dec_hit) begin
            sel_d   = dec_sel;
            s_req_d = dec_sel;
            state_d = ST_ACCESS;
`ifdef BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d    = ST_RESP;
            m_ready_d  = 1'b1;
            m_err_d    = 1'b1;
            m_rdata_d  = '0;
            err_addr_d = m_addr;
          end
        end
      end
      ST_ACCESS: begin
        // A ready arriving in the same cycle as the timeout still completes cleanly.
        if (sel_ready) begin
          s_req_d   = '0;
          state_d   = ST_RESP;
          m_ready_d = 1'b1;
          m_rdata_d = req_q.wen ? '0 : sel_rdata;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          s_req_d    = '0;
          state_d    = ST_RESP;
          m_ready_d  = 1'b1;
          m_err_d    = 1'b1;
          m_rdata_d  = '0;
          err_addr_d = req_q.addr;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        s_req_d = '0;
      end
    endcase
  end

  // Single register stage for FSM state and every registered output.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together from pre-edge values.
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      s_req_q    <= '0;
      req_q      <= '0;
      m_ready_q  <= 1'b0;
      m_err_q    <= 1'b0;
      m_rdata_q  <= '0;
      err_addr_q <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      s_req_q    <= s_req_d;
      req_q      <= req_d;
      m_ready_q  <= m_ready_d;
      m_err_q    <= m_err_d;
      m_rdata_q  <= m_rdata_d;
      err_addr_q <= err_addr_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign m_rdata  = m_rdata_q;
  assign m_ready  = m_ready_q;
  assign m_err    = m_err_q;
  assign err_addr = err_addr_q;
  assign s_req    = s_req_q;
  assign s_addr   = req_q.addr;
  assign s_wdata  = req_q.wdata;
  assign s_wen    = req_q.wen;
  assign s_be     = req_q.be;

endmodule
